// File: rtl/lab2_pkg.sv
// Shared lab2 serial-link definitions: minimum burst length and
// the deserializer state encoding.
package lab2_pkg;

  localparam int MIN_VALID_LEN = 3;

  typedef enum logic {
    IDLE,
    RECV
  } deser_state_t;

endpackage

// File: rtl/lab2_2_deser.sv
// lab2 serial-to-parallel receiver, MSB first, left-aligned words.
// Optional short-burst discard: LAB2_DESER_MIN_LEN_CHECK_EN.
module lab2_2_deser
  import lab2_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic                          ser_data_i,
  input  logic                          ser_data_val_i,
  output logic [DATA_WIDTH-1:0]         deser_data_o,
  output logic [$clog2(DATA_WIDTH):0]   deser_len_o,
  output logic                          deser_data_val_o,
  output logic                          deser_drop_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int LW = CW + 1;

  deser_state_t          state;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [LW-1:0]         cnt;
  logic [CW-1:0]         pos;

  // In RECV cnt never reaches DATA_WIDTH, so the low bits index safely
  assign pos = CW'(DATA_WIDTH - 1) - cnt[CW-1:0];

  always_comb begin
    sh_nxt      = sh;
    sh_nxt[pos] = ser_data_i;
  end

`ifndef LAB2_DESER_MIN_LEN_CHECK_EN
  assign deser_drop_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      sh               <= '0;
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
`ifdef LAB2_DESER_MIN_LEN_CHECK_EN
      deser_drop_o     <= 1'b0;
`endif
    end else begin
      deser_data_val_o <= 1'b0;
`ifdef LAB2_DESER_MIN_LEN_CHECK_EN
      deser_drop_o     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            sh    <= {ser_data_i, {(DATA_WIDTH-1){1'b0}}};
            cnt   <= LW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (ser_data_val_i) begin
            sh  <= sh_nxt;
            cnt <= cnt + LW'(1);
            if (cnt == LW'(DATA_WIDTH - 1)) begin
              deser_data_o     <= sh_nxt;
              deser_len_o      <= LW'(DATA_WIDTH);
              deser_data_val_o <= 1'b1;
              cnt              <= '0;
              state            <= IDLE;
            end
          end else begin
            cnt   <= '0;
            state <= IDLE;
`ifdef LAB2_DESER_MIN_LEN_CHECK_EN
            if (cnt < LW'(MIN_VALID_LEN)) begin
              deser_drop_o <= 1'b1;
            end else begin
              deser_data_o     <= sh;
              deser_len_o      <= cnt;
              deser_data_val_o <= 1'b1;
            end
`else
            deser_data_o     <= sh;
            deser_len_o      <= cnt;
            deser_data_val_o <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_2_deser.sv
// Directed table-driven bench for lab2_2_deser (DATA_WIDTH = 16).
// Drop expectations follow LAB2_DESER_MIN_LEN_CHECK_EN.
module tb_lab2_2_deser;

  localparam int DW = 16;
  localparam int LW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic          sd = 1'b0;
  logic          sv = 1'b0;
  logic [DW-1:0] dd;
  logic [LW-1:0] dl;
  logic          dv;
  logic          ddrop;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic          v;
    logic          b;
    logic          ev;
    logic          edrop;
    logic [DW-1:0] ed;
    logic [LW-1:0] el;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] hd;
  logic [LW-1:0] hl;

  always #5 clk = ~clk;

  lab2_2_deser #(.DATA_WIDTH(DW)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (sd),
    .ser_data_val_i   (sv),
    .deser_data_o     (dd),
    .deser_len_o      (dl),
    .deser_data_val_o (dv),
    .deser_drop_o     (ddrop)
  );

  // Expected data/len are the held values unless this row emits
  task automatic push(input logic v, input logic b,
                      input logic ev, input logic edrop,
                      input logic [DW-1:0] ed,
                      input logic [LW-1:0] el);
    vec_t r;
    if (ev) begin
      hd = ed;
      hl = el;
    end
    r.v     = v;
    r.b     = b;
    r.ev    = ev;
    r.edrop = edrop;
    r.ed    = hd;
    r.el    = hl;
    tbl.push_back(r);
  endtask

  task automatic burst(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, w[DW-1-i], 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check(input string name,
                       input logic ev, input logic edrop,
                       input logic [DW-1:0] ed,
                       input logic [LW-1:0] el);
    total++;
    if (dv === ev && ddrop === edrop && dd === ed && dl === el)
      passed++;
    else
      $display("FAIL %s: got val=%0b drop=%0b data=%h len=%0d, want val=%0b drop=%0b data=%h len=%0d",
               name, dv, ddrop, dd, dl, ev, edrop, ed, el);
  endtask

  task automatic short_end(input logic [DW-1:0] w, input int n);
`ifdef LAB2_DESER_MIN_LEN_CHECK_EN
    if (n < 3) push(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    else       push(1'b0, 1'b1, 1'b1, 1'b0, w, LW'(n));
`else
    push(1'b0, 1'b1, 1'b1, 1'b0, w, LW'(n));
`endif
  endtask

  logic [DW-1:0] w3;

  initial begin
    hd = '0;
    hl = '0;

    // 16 bits 0xA5C3: pulse right after bit 16, none after
    burst(16'hA5C3, 15);
    push(1'b1, 1'b1, 1'b1, 1'b0, 16'hA5C3, LW'(16));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    push(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

    // 5 bits 1,0,1,1,0: pulse after the val-low cycle
    burst(16'hB000, 5);
    push(1'b0, 1'b1, 1'b1, 1'b0, 16'hB000, LW'(5));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // 20 continuous bits: 0xFFFF then 1,0,1,0
    burst(16'hFFFF, 15);
    push(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, LW'(16));
    burst(16'hA000, 4);
    push(1'b0, 1'b0, 1'b1, 1'b0, 16'hA000, LW'(4));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // 2-bit burst: dropped with the check, else emitted
    burst(16'hC000, 2);
    short_end(16'hC000, 2);
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // 1-bit burst: minimum length
    burst(16'h8000, 1);
    short_end(16'h8000, 1);

    // 3-bit burst: exactly at the drop threshold, always emitted
    burst(16'h6000, 3);
    short_end(16'h6000, 3);

    // Two 4-bit bursts separated by one idle cycle
    burst(16'hF000, 4);
    push(1'b0, 1'b0, 1'b1, 1'b0, 16'hF000, LW'(4));
    burst(16'h9000, 4);
    push(1'b0, 1'b1, 1'b1, 1'b0, 16'h9000, LW'(4));
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Reset state
    srst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 1'b0, '0, '0);
    srst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      sv = tbl[i].v;
      sd = tbl[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].edrop,
            tbl[i].ed, tbl[i].el);
    end

    // Reset mid-burst after 7 bits: outputs clear at once
    for (int i = 0; i < 7; i++) begin
      sv = 1'b1;
      sd = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    srst = 1'b0;
    #1;
    check("rst_mid", 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    check("rst_hold", 1'b0, 1'b0, '0, '0);
    srst = 1'b1;

    // Fresh 16-bit burst after reset decodes cleanly
    w3 = 16'h3C5A;
    for (int i = 0; i < DW; i++) begin
      sv = 1'b1;
      sd = w3[DW-1-i];
      @(posedge clk);
      #1;
      if (i == DW - 1)
        check("post_rst_word", 1'b1, 1'b0, 16'h3C5A, LW'(16));
      else if (i == 3 || i == 10)
        check($sformatf("post_rst_bit%0d", i), 1'b0, 1'b0, '0, '0);
    end
    sv = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 1'b0, 1'b0, 16'h3C5A, LW'(16));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lab2_2_deser.md
# lab2_2_deser

Serial-to-parallel receiver for the lab2 serial link: accepts the MSB-first bit stream framed by a valid strobe and rebuilds left-aligned parallel words with their bit length. It sits at the far end of the serial link, directly fed by the serializer's `ser_data_o` / `ser_data_val_o` pair. It emits one word per burst, or one per DATA_WIDTH bits for longer bursts.

## Interface
- DATA_WIDTH, 16, parallel word width in bits; power of two, ≥ 4
- clk_i  input  1  clock; all logic on rising edge
- srst_i  input  1  reset, asynchronous, active-low
- ser_data_i  input  1  serial bit, MSB of the word first
- ser_data_val_i  input  1  bit qualifier; a burst is a run of consecutive high cycles
- deser_data_o  output  DATA_WIDTH  received word, left-aligned, unused LSBs zero
- deser_len_o  output  $clog2(DATA_WIDTH)+1  number of valid bits in deser_data_o, 1..DATA_WIDTH
- deser_data_val_o  output  1  one-cycle pulse qualifying deser_data_o / deser_len_o
- deser_drop_o  output  1  one-cycle pulse: a short burst was discarded (tied 0 without the macro)

## Operation
- Reset (srst_i low, any time, immediate): state IDLE, bit counter 0, shift register 0, all outputs 0. A partial word in flight is discarded without an output pulse.
- Internal: shift register `sh` (DATA_WIDTH), counter `cnt` (0..DATA_WIDTH).
- FSM states: IDLE, RECV.
- IDLE:
  - With ser_data_val_i = 1: sh = {ser_data_i, zeros}, cnt = 1, go to RECV.
  - Otherwise remain in IDLE.
- RECV, ser_data_val_i = 1:
  - The bit is written at position DATA_WIDTH-1-cnt, and cnt increments.
  - If the new cnt equals DATA_WIDTH, emit (sh with the new bit, len = DATA_WIDTH) on the same edge and go to IDLE.
- RECV, ser_data_val_i = 0:
  - End of burst. Emit (sh, len = cnt) and go to IDLE.
  - The LSBs below the last received bit are zero.
- Continuous bursts longer than DATA_WIDTH:
  - The word is emitted on bit DATA_WIDTH.
  - The next valid bit, in IDLE, starts a new word, so no bits are lost.
  - The tail is emitted at end of burst.
- A burst of exactly DATA_WIDTH bits produces a single pulse; the following val-low cycle in IDLE emits nothing.
- deser_data_o and deser_len_o hold their last emitted value between pulses.
- ser_data_i is ignored when ser_data_val_i = 0.

## Timing
- Full word: deser_data_val_o is high in the cycle immediately after the cycle carrying bit DATA_WIDTH.
- Partial word: deser_data_val_o is high in the cycle after the first val-low cycle, i.e. 2 cycles after the last bit.
- deser_data_val_o and deser_drop_o are registered, never high together, and each lasts exactly 1 cycle.
- Maximum pulse rate is one per DATA_WIDTH cycles under continuous valid. A 1-bit burst followed by a low cycle is the minimum burst and gives one pulse per 2 cycles.
- No backpressure; the consumer must accept each pulse.

## Configuration
- `LAB2_DESER_MIN_LEN_CHECK_EN` defined:
  - A burst ending with cnt < MIN_VALID_LEN (3) is not emitted. deser_drop_o pulses instead, with the same timing as the suppressed valid.
  - deser_data_o and deser_len_o keep their previous values.
  - Full DATA_WIDTH words are never dropped.
- Not defined: every burst of ≥ 1 bit is emitted, and deser_drop_o is constant 0.

## Structure
- Shared package `lab2_pkg`:
  - `MIN_VALID_LEN` = 3, shared with the serializer.
  - State enum typedef `deser_state_t` {IDLE, RECV}.
- Single module; no sub-module. The counter and shift register are small enough to be inline.

## Test plan
- Continuous 16 valid bits of 0xA5C3 (DATA_WIDTH = 16) → one pulse the cycle after bit 16; deser_data_o = 0xA5C3, deser_len_o = 16; no pulse on the following idle cycle.
- Burst of 5 bits 1,0,1,1,0 then val low → pulse 2 cycles after last bit; deser_data_o = 0xB000, deser_len_o = 5.
- Continuous 20 bits (0xFFFF then 1,0,1,0) → pulse with 0xFFFF/len 16, then pulse with 0xA000/len 4; no gap bits lost.
- Burst of 2 bits with macro defined → deser_drop_o pulse, no valid, outputs unchanged. Without macro → valid with len 2.
- srst_i pulsed low mid-burst after 7 bits → outputs 0 immediately. The next 16-bit burst decodes correctly with len 16.
- Two 4-bit bursts 0xF-pattern and 0x9-pattern separated by one idle cycle → two pulses, 0xF000/len 4 then 0x9000/len 4.
